// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single-port synchronous memory
// One transaction in flight: IDLE -> ACCESS -> (CAPTURE for reads) -> DONE -> IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              wr_a,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic              r_last_b;
  logic              r_sel_b;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;

  logic w_any_req;
  logic w_pick_b;
  logic w_busy;

  assign w_any_req = req_a | req_b;
  // B wins when alone, or on a tie when A was the last one served
  assign w_pick_b  = req_b & (~req_a | ~r_last_b);
  assign w_busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last_b  <= 1'b1;
      r_sel_b   <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ACCESS;
            r_sel_b <= w_pick_b;
            r_wr    <= w_pick_b ? wr_b    : wr_a;
            r_addr  <= w_pick_b ? addr_b  : addr_a;
            r_wdata <= w_pick_b ? wdata_b : wdata_a;
          end
        end
        S_ACCESS: begin
          r_state <= r_wr ? S_DONE : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_sel_b) begin
            r_rdata_b <= data_out;
          end else begin
            r_rdata_a <= data_out;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_last_b <= r_sel_b;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_a   = w_busy & ~r_sel_b;
  assign gnt_b   = w_busy &  r_sel_b;
  assign done_a  = (r_state == S_DONE) & ~r_sel_b;
  assign done_b  = (r_state == S_DONE) &  r_sel_b;
  assign read    = (r_state == S_ACCESS) & ~r_wr;
  assign write   = (r_state == S_ACCESS) &  r_wr;
  assign addr    = r_addr;
  assign data_in = r_wdata;
  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;

endmodule
